// File: rtl/count_step_checker.sv
// rtl/count_step_checker.sv - step checker for the 4-bit mode counter
//
// Watches the mode counter output and its mode bit every clock. Each step is
// checked against the counter's next-state rule. Mismatches pulse err and bump
// err_cnt. Matched wrap steps bump wrap_cnt. A run of ERR_LIMIT consecutive
// mismatches latches fault until reset or clr.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-low reset, highest priority
//   chk_en   - enable checking (low: drop to IDLE and hold)
//   clr      - synchronous clear of counters, fault and history
//   w_in     - mode bit seen by the counter (1: +2, 0: -1)
//   cnt_in   - counter value
//   err      - one-cycle pulse per mismatched step
//   fault    - sticky fault flag
//   err_cnt  - saturating mismatch count
//   wrap_cnt - saturating matched-wrap count
//   exp_out  - registered expected value for the current edge

module count_step_checker #(
    parameter int ERR_LIMIT = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             clr,
    input  logic             w_in,
    input  logic [3:0]       cnt_in,
    output logic             err,
    output logic             fault,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [3:0]       exp_out
);

    localparam int             CW       = $clog2(ERR_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT_M1 = CW'(ERR_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      prev_cnt;
    logic            prev_w;
    logic [CW-1:0]   consec_q;

    logic            capture;
    logic            matched;
    logic            mismatch;
    logic            wrap_hit;
    logic            go_fault;
    logic [3:0]      step_exp;

    // Counter next-state rule: +2 mode forces 8 and 15 back to 0,
    // otherwise steps mod 16; -1 mode wraps 0 to 15.
    function automatic logic [3:0] step_f(input logic [3:0] p, input logic m);
        logic [3:0] r;
        if (m) begin
            if (p == 4'd8 || p == 4'd15) r = 4'd0;
            else                         r = p + 4'd2;
        end else begin
            if (p == 4'd0) r = 4'd15;
            else           r = p - 4'd1;
        end
        return r;
    endfunction

    // A wrap is any step whose natural result passes through 0/15.
    function automatic logic is_wrap(input logic [3:0] p, input logic m);
        logic r;
        if (m) r = (p == 4'd8) || (p == 4'd14) || (p == 4'd15);
        else   r = (p == 4'd0);
        return r;
    endfunction

    assign step_exp = step_f(prev_cnt, prev_w);

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        matched  = 1'b0;
        mismatch = 1'b0;
        wrap_hit = 1'b0;
        go_fault = 1'b0;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (chk_en) begin
                        capture = 1'b1;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (chk_en) begin
                        // Always resync to the current sample so a single bad
                        // value costs exactly one error.
                        capture = 1'b1;
                        if (cnt_in != step_exp) begin
                            mismatch = 1'b1;
                            if (consec_q == LIMIT_M1) begin
                                go_fault = 1'b1;
                                state_d  = FAULT;
                            end
                        end else begin
                            matched  = 1'b1;
                            wrap_hit = is_wrap(prev_cnt, prev_w);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            prev_cnt <= 4'd0;
            prev_w   <= 1'b0;
            exp_out  <= 4'd0;
            consec_q <= '0;
            err      <= 1'b0;
            fault    <= 1'b0;
            err_cnt  <= '0;
            wrap_cnt <= '0;
        end else begin
            state_q <= state_d;
            err     <= mismatch;
            if (clr) begin
                prev_cnt <= 4'd0;
                prev_w   <= 1'b0;
                exp_out  <= 4'd0;
                consec_q <= '0;
                fault    <= 1'b0;
                err_cnt  <= '0;
                wrap_cnt <= '0;
            end else begin
                if (capture) begin
                    prev_cnt <= cnt_in;
                    prev_w   <= w_in;
                    // Expected value for the next edge, so exp_out lines up
                    // with the sample it will be compared against.
                    exp_out  <= step_f(cnt_in, w_in);
                end
                if (mismatch) begin
                    consec_q <= consec_q + CW'(1);
                    if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
                end else if (matched) begin
                    consec_q <= '0;
                end
                if (wrap_hit && wrap_cnt != CNT_MAX) begin
                    wrap_cnt <= wrap_cnt + CNT_W'(1);
                end
                if (go_fault) fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_step_checker.sv
// tb/tb_count_step_checker.sv - directed vector bench for count_step_checker

module tb_count_step_checker;

    typedef struct {
        logic       rstn;
        logic       en;
        logic       clr;
        logic       w;
        logic [3:0] cnt;
        logic       e_err;
        logic       e_fault;
        logic [7:0] e_errc;
        logic [7:0] e_wrap;
        logic [3:0] e_exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, chk_en, clr, w_in;
    logic [3:0] cnt_in;

    logic       err, fault;
    logic [7:0] err_cnt, wrap_cnt;
    logic [3:0] exp_out;

    logic       s_err, s_fault;
    logic [1:0] s_err_cnt, s_wrap_cnt;
    logic [3:0] s_exp_out;

    int checks   = 0;
    int failures = 0;
    int row      = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    count_step_checker #(.ERR_LIMIT(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .chk_en(chk_en), .clr(clr), .w_in(w_in),
        .cnt_in(cnt_in), .err(err), .fault(fault), .err_cnt(err_cnt),
        .wrap_cnt(wrap_cnt), .exp_out(exp_out)
    );

    count_step_checker #(.ERR_LIMIT(3), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .chk_en(chk_en), .clr(clr), .w_in(w_in),
        .cnt_in(cnt_in), .err(s_err), .fault(s_fault), .err_cnt(s_err_cnt),
        .wrap_cnt(s_wrap_cnt), .exp_out(s_exp_out)
    );

    function automatic vec_t mk(input logic rstn, input logic en, input logic c,
                                input logic w, input int cnt, input logic e_err,
                                input logic e_fault, input int e_errc,
                                input int e_wrap, input int e_exp);
        vec_t v;
        v.rstn = rstn; v.en = en; v.clr = c; v.w = w; v.cnt = cnt[3:0];
        v.e_err = e_err; v.e_fault = e_fault;
        v.e_errc = e_errc[7:0]; v.e_wrap = e_wrap[7:0]; v.e_exp = e_exp[3:0];
        return v;
    endfunction

    function automatic logic [7:0] sat3(input logic [7:0] v);
        return (v > 8'd3) ? 8'd3 : v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset  = v.rstn;
        chk_en = v.en;
        clr    = v.clr;
        w_in   = v.w;
        cnt_in = v.cnt;
        @(posedge clk);
        #1;
        chk("err",        {7'd0, err},       {7'd0, v.e_err});
        chk("fault",      {7'd0, fault},     {7'd0, v.e_fault});
        chk("err_cnt",    err_cnt,           v.e_errc);
        chk("wrap_cnt",   wrap_cnt,          v.e_wrap);
        chk("exp_out",    {4'd0, exp_out},   {4'd0, v.e_exp});
        chk("s_err",      {7'd0, s_err},     {7'd0, v.e_err});
        chk("s_fault",    {7'd0, s_fault},   {7'd0, v.e_fault});
        chk("s_err_cnt",  {6'd0, s_err_cnt}, sat3(v.e_errc));
        chk("s_wrap_cnt", {6'd0, s_wrap_cnt},sat3(v.e_wrap));
        chk("s_exp_out",  {4'd0, s_exp_out},{4'd0, v.e_exp});
        row++;
    endtask

    initial begin
        reset = 1'b0; chk_en = 1'b0; clr = 1'b0; w_in = 1'b0; cnt_in = 4'd0;

        //        rstn en clr w cnt   err flt errc wrap exp
        vq.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0,  0));
        vq.push_back(mk(0, 1, 1, 1,  5,  0, 0, 0, 0,  0));
        // +2 run through the 8->0 wrap
        vq.push_back(mk(1, 1, 0, 1,  0,  0, 0, 0, 0,  2));
        vq.push_back(mk(1, 1, 0, 1,  2,  0, 0, 0, 0,  4));
        vq.push_back(mk(1, 1, 0, 1,  4,  0, 0, 0, 0,  6));
        vq.push_back(mk(1, 1, 0, 1,  6,  0, 0, 0, 0,  8));
        vq.push_back(mk(1, 1, 0, 1,  8,  0, 0, 0, 0,  0));
        vq.push_back(mk(1, 1, 0, 1,  0,  0, 0, 0, 1,  2));
        vq.push_back(mk(1, 1, 0, 1,  2,  0, 0, 0, 1,  4));
        // drop to IDLE, then -1 run through 0->15
        vq.push_back(mk(1, 0, 0, 1,  3,  0, 0, 0, 1,  4));
        vq.push_back(mk(1, 1, 0, 0,  2,  0, 0, 0, 1,  1));
        vq.push_back(mk(1, 1, 0, 0,  1,  0, 0, 0, 1,  0));
        vq.push_back(mk(1, 1, 0, 0,  0,  0, 0, 0, 1, 15));
        vq.push_back(mk(1, 1, 0, 0, 15,  0, 0, 0, 2, 14));
        vq.push_back(mk(1, 1, 0, 0, 14,  0, 0, 0, 2, 13));
        // switch to +2 at 13: 13->15 no wrap, 15->0 wrap
        vq.push_back(mk(1, 1, 0, 1, 13,  0, 0, 0, 2, 15));
        vq.push_back(mk(1, 1, 0, 1, 15,  0, 0, 0, 2,  0));
        vq.push_back(mk(1, 1, 0, 1,  0,  0, 0, 0, 3,  2));
        // single bad value then resync
        vq.push_back(mk(1, 1, 0, 1,  2,  0, 0, 0, 3,  4));
        vq.push_back(mk(1, 1, 0, 1,  5,  1, 0, 1, 3,  7));
        vq.push_back(mk(1, 1, 0, 1,  7,  0, 0, 1, 3,  9));
        // three consecutive bad steps -> FAULT
        vq.push_back(mk(1, 0, 0, 1,  0,  0, 0, 1, 3,  9));
        vq.push_back(mk(1, 1, 0, 1,  0,  0, 0, 1, 3,  2));
        vq.push_back(mk(1, 1, 0, 1,  5,  1, 0, 2, 3,  7));
        vq.push_back(mk(1, 1, 0, 1,  1,  1, 0, 3, 3,  3));
        vq.push_back(mk(1, 1, 0, 1,  9,  1, 1, 4, 3, 11));
        vq.push_back(mk(1, 1, 0, 1,  3,  0, 1, 4, 3, 11));
        vq.push_back(mk(1, 1, 0, 0,  4,  0, 1, 4, 3, 11));
        // clr overrides chk_en and leaves FAULT
        vq.push_back(mk(1, 1, 1, 1,  5,  0, 0, 0, 0,  0));
        vq.push_back(mk(1, 1, 0, 0,  6,  0, 0, 0, 0,  5));
        vq.push_back(mk(1, 1, 0, 0,  5,  0, 0, 0, 0,  4));
        // reset mid-TRACK with a bad sample present
        vq.push_back(mk(0, 1, 0, 1,  9,  0, 0, 0, 0,  0));
        vq.push_back(mk(1, 1, 0, 1,  3,  0, 0, 0, 0,  5));
        // five isolated mismatches: CNT_W=2 copy saturates at 3
        vq.push_back(mk(1, 1, 0, 1,  0,  1, 0, 1, 0,  2));
        vq.push_back(mk(1, 1, 0, 1,  2,  0, 0, 1, 0,  4));
        vq.push_back(mk(1, 1, 0, 1,  0,  1, 0, 2, 0,  2));
        vq.push_back(mk(1, 1, 0, 1,  2,  0, 0, 2, 0,  4));
        vq.push_back(mk(1, 1, 0, 1,  0,  1, 0, 3, 0,  2));
        vq.push_back(mk(1, 1, 0, 1,  2,  0, 0, 3, 0,  4));
        vq.push_back(mk(1, 1, 0, 1,  0,  1, 0, 4, 0,  2));
        vq.push_back(mk(1, 1, 0, 1,  2,  0, 0, 4, 0,  4));
        vq.push_back(mk(1, 1, 0, 1,  0,  1, 0, 5, 0,  2));

        #2;
        for (int i = 0; i < vq.size(); i++) apply(vq[i]);

        // Hand sequence: reach FAULT again, chk_en low must not exit it,
        // only reset does.
        apply(mk(1, 1, 0, 1,  2,  0, 0, 5, 0,  4));
        apply(mk(1, 1, 0, 1,  5,  1, 0, 6, 0,  7));
        apply(mk(1, 1, 0, 1,  1,  1, 0, 7, 0,  3));
        apply(mk(1, 1, 0, 1,  9,  1, 1, 8, 0, 11));
        apply(mk(1, 0, 0, 1,  2,  0, 1, 8, 0, 11));
        apply(mk(0, 1, 0, 1,  2,  0, 0, 0, 0,  0));
        // After reset, first IDLE capture then a clean step.
        apply(mk(1, 1, 0, 0,  0,  0, 0, 0, 0, 15));
        apply(mk(1, 1, 0, 0, 15,  0, 0, 0, 1, 14));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
